// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared types and helpers for the shift-add multiplier
package seq_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Widest operand the magnitude helper handles; callers cast the result down.
  localparam int MAX_W = 64;

  function automatic int count_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  // Magnitude of a width-bit value held zero-extended in v; raw value when unsigned.
  // The most-negative input maps to 2^(width-1), which still fits width bits.
  function automatic logic [MAX_W-1:0] abs_ext(input logic [MAX_W-1:0] v,
                                               input int width,
                                               input logic is_signed);
    logic msb;
    msb = |(v & (MAX_W'(1) << (width - 1)));
    return (is_signed && msb) ? -v : v;
  endfunction

endpackage

// File: rtl/seq_mult_dp.sv
// rtl/seq_mult_dp.sv - accumulator, operand shifters and sign fix for the multiplier
module seq_mult_dp
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               last,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               rest_zero,
  output logic [2*WIDTH-1:0] out_data
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mag1_q, mag1_d;
  logic [2*WIDTH-1:0] mag2_q, mag2_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [2*WIDTH-1:0] term, sum;

  assign abs1 = WIDTH'(abs_ext(MAX_W'(in1), WIDTH, in_signed));
  assign abs2 = WIDTH'(abs_ext(MAX_W'(in2), WIDTH, in_signed));

  // Next-state of the datapath: capture magnitudes on accept, add-and-shift per step.
  always_comb begin
    acc_d      = acc_q;
    mag1_d     = mag1_q;
    mag2_d     = mag2_q;
    neg_d      = neg_q;
    out_data_d = out_data_q;
    term       = mag1_q[0] ? mag2_q : '0;
    sum        = acc_q + term;
    if (load) begin
      acc_d  = '0;
      mag1_d = abs1;
      mag2_d = {{WIDTH{1'b0}}, abs2};
      neg_d  = in_signed & (in1[WIDTH-1] ^ in2[WIDTH-1]);
    end else if (step) begin
      acc_d  = sum;
      mag1_d = mag1_q >> 1;
      mag2_d = mag2_q << 1;
      if (last) begin
        out_data_d = neg_q ? -sum : sum;
      end
    end
  end

  // Datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q      <= '0;
      mag1_q     <= '0;
      mag2_q     <= '0;
      neg_q      <= 1'b0;
      out_data_q <= '0;
    end else begin
      acc_q      <= acc_d;
      mag1_q     <= mag1_d;
      mag2_q     <= mag2_d;
      neg_q      <= neg_d;
      out_data_q <= out_data_d;
    end
  end

  // Multiplier bits still to be scanned after this step's shift are all zero.
  assign rest_zero = (mag1_q >> 1) == '0;
  assign out_data  = out_data_q;

endmodule

// File: rtl/seq_mult_hs.sv
// rtl/seq_mult_hs.sv - handshaked shift-add sequential multiplier, control FSM
module seq_mult_hs
  import seq_mult_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_data,
  output logic               busy
);

  localparam int CW = count_width(WIDTH);

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            out_valid_q, out_valid_d;
  logic            load, step, last, rest_zero;

  // A result leaving DONE frees the block for new operands on the same edge.
  assign in_ready = rst_n &&
                    ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));

  // Next state, step counter and result-valid control.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    load        = 1'b0;
    step        = 1'b0;
    last        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          load    = 1'b1;
          count_d = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        step    = 1'b1;
        last    = (count_q == CW'(WIDTH - 1)) || ((EARLY_EXIT != 0) && rest_zero);
        count_d = count_q + 1'b1;
        if (last) begin
          count_d     = '0;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
          if (in_valid && in_ready) begin
            load    = 1'b1;
            count_d = '0;
            state_d = ST_BUSY;
          end
        end
      end
      default: begin
        out_valid_d = 1'b0;
        count_d     = '0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Control registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  seq_mult_dp #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .step      (step),
    .last      (last),
    .in_signed (in_signed),
    .in1       (in1),
    .in2       (in2),
    .rest_zero (rest_zero),
    .out_data  (out_data)
  );

  assign out_valid = out_valid_q;
  assign busy      = (state_q == ST_BUSY);

endmodule

// File: tb/tb_seq_mult_hs.sv
// tb/tb_seq_mult_hs.sv - directed and random checks of seq_mult_hs at two widths
module tb_seq_mult_hs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_signed;
  logic        out_ready;
  logic [15:0] in1, in2;
  logic [2:0]  iv;
  logic [2:0]  ir, ov, bz;
  logic [15:0] od_a, od_b;
  logic [31:0] od_c;
  logic [1:0]  sel;
  logic        cur_ir, cur_ov, cur_bz;
  logic [31:0] cur_od;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  seq_mult_hs #(.WIDTH(8), .EARLY_EXIT(0)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_signed(in_signed), .in1(in1[7:0]), .in2(in2[7:0]),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od_a), .busy(bz[0])
  );

  seq_mult_hs #(.WIDTH(8), .EARLY_EXIT(1)) u_w8e (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_signed(in_signed), .in1(in1[7:0]), .in2(in2[7:0]),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od_b), .busy(bz[1])
  );

  seq_mult_hs #(.WIDTH(16), .EARLY_EXIT(0)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_signed(in_signed), .in1(in1), .in2(in2),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od_c), .busy(bz[2])
  );

  always_comb begin
    cur_ir = 1'b0;
    cur_ov = 1'b0;
    cur_bz = 1'b0;
    cur_od = '0;
    case (sel)
      2'd0: begin cur_ir = ir[0]; cur_ov = ov[0]; cur_bz = bz[0]; cur_od = {16'h0, od_a}; end
      2'd1: begin cur_ir = ir[1]; cur_ov = ov[1]; cur_bz = bz[1]; cur_od = {16'h0, od_b}; end
      2'd2: begin cur_ir = ir[2]; cur_ov = ov[2]; cur_bz = bz[2]; cur_od = od_c; end
      default: ;
    endcase
  end

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic s, input int w);
    longint sa, sb, p;
    longint full;
    full = longint'(1) << w;
    sa = longint'(a) & (full - 1);
    sb = longint'(b) & (full - 1);
    if (s && (sa >= (full >> 1))) sa = sa - full;
    if (s && (sb >= (full >> 1))) sb = sb - full;
    p = sa * sb;
    return (w == 16) ? p[31:0] : {16'h0, p[15:0]};
  endfunction

  function automatic int ee_lat(input logic [7:0] a, input logic s);
    int mag, lat;
    mag = (s && a >= 8'h80) ? (256 - int'(a)) : int'(a);
    lat = 1;
    for (int i = 0; i < 8; i++) if ((mag >> i) & 1) lat = i + 1;
    return lat;
  endfunction

  // Present operands to DUT d and step past the accepting edge.
  task automatic start_op(input logic [1:0] d, input logic [15:0] a, input logic [15:0] b,
                          input logic s);
    int n = 0;
    sel = d;
    in1 = a;
    in2 = b;
    in_signed = s;
    iv = 3'b001 << d;
    #1;
    while (!cur_ir && n < 50) begin
      @(negedge clk);
      n++;
    end
    expect_eq("accept_wait", (n < 50) ? 1 : 0, 1);
    @(posedge clk);
    @(negedge clk);
    iv = '0;
  endtask

  // Wait for the result, check latency/value, optionally stall and poke in_valid while busy.
  task automatic finish_op(input string tag, input logic [31:0] exp, input int lat,
                           input int hold, input bit poke, input bit leave);
    int edges = 0;
    out_ready = (hold == 0);
    if (poke) begin
      in1 = 16'hA5A5;
      in2 = 16'h5A5A;
      iv = 3'b001 << sel;
    end
    #1;
    while (!cur_ov && edges < 200) begin
      if (poke) expect_eq({tag, "_busy_in_ready"}, {31'h0, cur_ir}, 0);
      @(negedge clk);
      edges++;
    end
    iv = '0;
    expect_eq({tag, "_latency"}, edges, lat);
    expect_eq({tag, "_data"}, cur_od, exp);
    expect_eq({tag, "_busy_in_done"}, {31'h0, cur_bz}, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      expect_eq({tag, "_hold_valid"}, {31'h0, cur_ov}, 1);
      expect_eq({tag, "_hold_data"}, cur_od, exp);
      expect_eq({tag, "_hold_in_ready"}, {31'h0, cur_ir}, 0);
    end
    if (!leave) begin
      out_ready = 1'b1;
      @(negedge clk);
      expect_eq({tag, "_valid_drop"}, {31'h0, cur_ov}, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [15:0] a, b;
    logic        s;
    int          h;
    rst_n = 1'b0;
    iv = '0;
    in1 = '0;
    in2 = '0;
    in_signed = 1'b0;
    out_ready = 1'b0;
    sel = 2'd0;
    repeat (2) @(negedge clk);
    expect_eq("rst_in_ready", {29'h0, ir}, 0);
    expect_eq("rst_out_valid", {29'h0, ov}, 0);
    expect_eq("rst_busy", {29'h0, bz}, 0);
    expect_eq("rst_data_a", {16'h0, od_a}, 0);
    expect_eq("rst_data_c", od_c, 0);
    rst_n = 1'b1;
    @(negedge clk);
    expect_eq("idle_in_ready", {29'h0, ir}, 3'b111);

    // Directed, WIDTH=8
    start_op(0, 16'd13, 16'd11, 0);
    expect_eq("busy_after_accept", {31'h0, cur_bz}, 1);
    finish_op("u13x11", 32'd143, 8, 0, 0, 0);
    start_op(0, 16'h80, 16'h80, 1);  finish_op("s_m128sq", 32'h4000, 8, 0, 0, 0);
    start_op(0, 16'hFD, 16'h05, 1);  finish_op("s_m3x5", 32'hFFF1, 8, 0, 0, 0);
    start_op(0, 16'hFF, 16'hFF, 0);  finish_op("u255sq", 32'd65025, 8, 0, 0, 0);
    start_op(0, 16'hFF, 16'hFF, 1);  finish_op("s_m1sq", 32'd1, 8, 0, 0, 0);
    start_op(0, 16'h7F, 16'h80, 1);  finish_op("s_127xm128", 32'hC080, 8, 0, 0, 0);

    // Backpressure then back-to-back accept
    start_op(0, 16'd13, 16'd11, 0);
    finish_op("stall", 32'd143, 8, 5, 0, 1);
    in1 = 16'd7;
    in2 = 16'd6;
    in_signed = 1'b0;
    iv = 3'b001;
    out_ready = 1'b1;
    #1;
    expect_eq("b2b_in_ready", {31'h0, cur_ir}, 1);
    @(posedge clk);
    @(negedge clk);
    iv = '0;
    expect_eq("b2b_valid_low", {31'h0, cur_ov}, 0);
    expect_eq("b2b_busy", {31'h0, cur_bz}, 1);
    finish_op("b2b_7x6", 32'd42, 8, 0, 0, 0);

    // Early exit
    start_op(1, 16'd1, 16'd200, 0);   finish_op("ee_1x200", 32'd200, 1, 0, 0, 0);
    start_op(1, 16'd0, 16'd55, 0);    finish_op("ee_0x55", 32'd0, 1, 0, 0, 0);
    start_op(1, 16'h80, 16'd3, 0);    finish_op("ee_128x3", 32'd384, 8, 0, 0, 0);
    start_op(1, 16'hFE, 16'd9, 1);    finish_op("ee_m2x9", 32'hFFEE, 2, 0, 0, 0);

    // Directed, WIDTH=16
    start_op(2, 16'hFFFF, 16'hFFFF, 0); finish_op("w16_umax", 32'hFFFE0001, 16, 0, 0, 0);
    start_op(2, 16'h8000, 16'h8000, 1); finish_op("w16_smin", 32'h40000000, 16, 0, 0, 0);
    start_op(2, 16'd300, 16'hFFFE, 1);  finish_op("w16_300xm2", 32'hFFFFFDA8, 16, 0, 0, 0);

    // Reset mid-operation at count 3
    start_op(0, 16'd100, 16'd100, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    expect_eq("midrst_in_ready", {31'h0, cur_ir}, 0);
    @(negedge clk);
    expect_eq("midrst_valid", {31'h0, cur_ov}, 0);
    expect_eq("midrst_data", cur_od, 0);
    expect_eq("midrst_busy", {31'h0, cur_bz}, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    expect_eq("midrst_no_result", {31'h0, cur_ov}, 0);
    start_op(0, 16'd9, 16'd9, 0);     finish_op("post_rst_9x9", 32'd81, 8, 0, 0, 0);

    // Random sweep with backpressure and in_valid held during BUSY
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 12; n++) begin
        a = 16'($urandom);
        b = 16'($urandom);
        s = 1'($urandom_range(0, 1));
        h = $urandom_range(0, 3);
        if (d != 2) begin
          a[15:8] = 8'h0;
          b[15:8] = 8'h0;
        end
        start_op(2'(d), a, b, s);
        finish_op("rnd", ref_mul(a, b, s, (d == 2) ? 16 : 8),
                  (d == 1) ? ee_lat(a[7:0], s) : ((d == 2) ? 16 : 8),
                  h, h > 0, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult_hs.md
Name: seq_mult_hs

Overview:
- Parametrised shift-add sequential multiplier.
- Next generation of the team's 8-bit iterative multiplier, with the following additions:
  - generic operand width;
  - per-operation signed/unsigned mode;
  - valid/ready handshakes on input and output;
  - optional early termination.
- Sits between an operand producer and a result consumer; one multiplication in flight at a time.

Parameters:
- WIDTH, 8, operand width in bits (>=2); product width is 2*WIDTH.
- EARLY_EXIT, 0, 1 = finish as soon as remaining multiplier bits are all zero.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands this cycle.
- in_signed  in  1  1 = treat in1/in2 as two's complement; sampled with operands.
- in1  in  WIDTH  multiplier operand (bits scanned LSB first).
- in2  in  WIDTH  multiplicand operand.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  2*WIDTH  product (two's complement if signed op).
- busy  out  1  high in BUSY state.

Behaviour:
- Reset: one clock, synchronous active-low reset; rst_n low at a rising edge gives:
  - state IDLE;
  - out_valid=0, out_data=0, busy=0;
  - all internal accumulator, shift and count registers 0.
- in_ready is 0 while rst_n low. Reset mid-operation aborts silently; no result is produced.
- States: IDLE, BUSY, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accept:
  - Condition: in_valid && in_ready at an edge.
  - Action: capture mag1=|in1|, mag2=|in2| (abs only if in_signed, else raw), neg=in_signed&&(in1[MSB]^in2[MSB]), acc=0, count=0, then go to BUSY.
  - Abs of the most-negative value (e.g. -128 for WIDTH=8) gives magnitude 2^(WIDTH-1); this must fit the unsigned WIDTH-bit register.
- BUSY, each edge:
  - if mag1[0], acc += mag2 shifted into a 2*WIDTH register;
  - mag1 >>= 1, mag2 <<= 1, count++.
- BUSY exit: the step where count==WIDTH-1 is last. With EARLY_EXIT=1, the step is also last when the post-shift mag1==0.
- On the last step: out_data <= neg ? -(acc+term) : (acc+term); out_valid<=1; state DONE.
- Latency: out_valid rises exactly WIDTH edges after the accepting edge when EARLY_EXIT=0. With EARLY_EXIT=1, latency is max(1, index of highest set bit of |in1| + 1) edges.
- DONE:
  - out_data/out_valid held stable while out_ready=0.
  - On out_ready: out_valid drops next edge and state goes to IDLE.
  - If in_valid is also high on that same edge, new operands are accepted and state goes straight to BUSY (back-to-back, no bubble). out_valid is 0 in BUSY.
- in_valid while BUSY: ignored, not accepted; the producer must hold.
- Inputs in1/in2/in_signed are don't-care outside accept edges.
- Invariants:
  - acc unsigned magnitude never decreases during BUSY;
  - acc never exceeds (2^WIDTH-1)^2;
  - count<=WIDTH-1;
  - out_valid implies state==DONE.
- Arithmetic: all internal sums are 2*WIDTH bits and never overflow. The signed result equals the exact 2*WIDTH-bit two's-complement product.

Decomposition:
- Package seq_mult_pkg holds:
  - state enum typedef (IDLE/BUSY/DONE);
  - function to compute count width, $clog2(WIDTH);
  - function abs_ext (conditional magnitude).
- One sub-module, seq_mult_dp: datapath holding the acc/mag1/mag2 registers and the sign fix. The FSM stays in the top.

Test Plan:
- WIDTH=8, unsigned 13*11, out_ready=1 -> out_data=143, out_valid exactly 8 edges after accept, single-cycle pulse.
- Signed -128*-128 -> 16384 (0x4000); signed -3*5 -> 0xFFF1; unsigned 255*255 -> 65025.
- out_ready held low 5 cycles in DONE -> out_data/out_valid stable, in_ready=0. Then out_ready=1 with in_valid=1 (7*6) -> accepted same edge; next result 42 with no idle cycle.
- EARLY_EXIT=1: in1=1,in2=200 -> 200 after 1 edge; in1=0 -> 0 after 1 edge; in1=0x80 -> 8 edges.
- rst_n low for one edge at BUSY count=3 -> IDLE, out_valid=0, out_data=0. A subsequent 9*9 yields 81 with full latency.
- Random signed/unsigned sweep at WIDTH=8 and WIDTH=16 against a reference model, with random out_ready backpressure -> all match; in_valid during BUSY never accepted.
